// File: rtl/fetch_hazard_controller_pkg.sv
// Shared definitions for the front-end hazard controller.
package fetch_hazard_controller_pkg;

  // Controller state encoding, also exported on the STATE debug port.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_IMISS    = 2'd1,
    ST_DMISS    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int DEFAULT_COUNTER_WIDTH = 32;

endpackage

// File: rtl/fetch_hazard_controller_counter.sv
// Saturating up-counter used for the performance statistics.
module saturating_counter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             INC,
  output logic [WIDTH-1:0] COUNT
);

  // Count up on INC, stick at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      COUNT <= '0;
    end else if (INC && (COUNT != {WIDTH{1'b1}})) begin
      COUNT <= COUNT + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_hazard_controller.sv
// Front-end hazard controller: converts redirect, load-use, I-miss and
// D-busy conditions into PC / IF/ID / ID/EX stall and flush strobes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal fetch
// IMISS    | waiting for the I-cache to return the instruction at PC
// DMISS    | memory stage busy, whole front end frozen
// REDIRECT | draining wrong-path fetches after a mispredict
module fetch_hazard_controller
  import fetch_hazard_controller_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
  parameter int FLUSH_CYCLES  = 2,
  parameter int CNT_WIDTH     = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     PC_MISPREDICT_SELECT,
  input  logic                     LOAD_USE_HAZARD,
  input  logic                     ICACHE_HIT,
  input  logic                     MEM_LOAD_STORE,
  input  logic                     DCACHE_READY,
  output logic                     STALL_PROGRAME_COUNTER_STAGE,
  output logic                     STALL_IF_ID,
  output logic                     STALL_ID_EX,
  output logic                     FLUSH_IF_ID,
  output logic                     FLUSH_ID_EX,
  output logic [1:0]               STATE,
  output logic [COUNTER_WIDTH-1:0] MISPREDICT_COUNT,
  output logic [COUNTER_WIDTH-1:0] STALL_CYCLE_COUNT
);

  localparam logic [CNT_WIDTH-1:0] FLUSH_LOAD = CNT_WIDTH'(FLUSH_CYCLES - 1);

  state_t               state_q, state_nxt;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_nxt;
  logic                 mem_block;
  logic                 redirect_taken;
  logic                 stall_pc_c, stall_if_id_c, stall_id_ex_c;
  logic                 flush_if_id_c, flush_id_ex_c;

  assign mem_block = MEM_LOAD_STORE & ~DCACHE_READY;

  // Prioritised hazard decode; outputs are Mealy on state and inputs.
  always_comb begin
    stall_pc_c     = LOW;
    stall_if_id_c  = LOW;
    stall_id_ex_c  = LOW;
    flush_if_id_c  = LOW;
    flush_id_ex_c  = LOW;
    redirect_taken = LOW;
    state_nxt      = state_q;
    cnt_nxt        = cnt_q;
    if (mem_block) begin
      // Execute is frozen, so any pending mispredict is still asserted later.
      stall_pc_c    = HIGH;
      stall_if_id_c = HIGH;
      stall_id_ex_c = HIGH;
      state_nxt     = ST_DMISS;
    end else if (PC_MISPREDICT_SELECT) begin
      flush_if_id_c  = HIGH;
      flush_id_ex_c  = HIGH;
      redirect_taken = HIGH;
      cnt_nxt        = FLUSH_LOAD;
      if (FLUSH_CYCLES == 1) begin
        state_nxt = ST_RUN;
      end else begin
        state_nxt = ST_REDIRECT;
      end
    end else if (state_q == ST_REDIRECT) begin
      // IF/ID is being discarded, so load-use and I-miss do not matter here.
      flush_if_id_c = HIGH;
      if (cnt_q != '0) begin
        cnt_nxt = cnt_q - 1'b1;
      end
      if (cnt_q <= CNT_WIDTH'(1)) begin
        state_nxt = ST_RUN;
      end
    end else if (LOAD_USE_HAZARD) begin
      stall_pc_c    = HIGH;
      stall_if_id_c = HIGH;
      flush_id_ex_c = HIGH;
    end else if (!ICACHE_HIT) begin
      stall_pc_c    = HIGH;
      flush_if_id_c = HIGH;
      state_nxt     = ST_IMISS;
    end else begin
      state_nxt = ST_RUN;
    end
  end

  // State and redirect-flush down-counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Everything is held (stalled and flushed) while reset is asserted.
  always_comb begin
    STALL_PROGRAME_COUNTER_STAGE = RST_N ? stall_pc_c    : HIGH;
    STALL_IF_ID                  = RST_N ? stall_if_id_c : HIGH;
    STALL_ID_EX                  = RST_N ? stall_id_ex_c : HIGH;
    FLUSH_IF_ID                  = RST_N ? flush_if_id_c : HIGH;
    FLUSH_ID_EX                  = RST_N ? flush_id_ex_c : HIGH;
    STATE                        = state_q;
  end

  saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_mispredict_count (
    .CLK   (CLK),
    .RST_N (RST_N),
    .INC   (redirect_taken),
    .COUNT (MISPREDICT_COUNT)
  );

  saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_cycle_count (
    .CLK   (CLK),
    .RST_N (RST_N),
    .INC   (stall_pc_c),
    .COUNT (STALL_CYCLE_COUNT)
  );

endmodule

// File: tb/tb_fetch_hazard_controller.sv
// Directed scoreboard bench for fetch_hazard_controller (4-bit counters).
module tb_fetch_hazard_controller;

  localparam int CW = 4;

  typedef struct packed {
    logic [4:0]    ctl;   // {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex}
    logic [1:0]    st;
    logic [CW-1:0] mc;
    logic [CW-1:0] sc;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          mis = 1'b0, lu = 1'b0, hit = 1'b1, mls = 1'b0, drdy = 1'b0;
  logic          s_pc, s_ifid, s_idex, f_ifid, f_idex;
  logic [1:0]    state;
  logic [CW-1:0] mcount, scount;

  exp_t  sb_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  fetch_hazard_controller #(
    .COUNTER_WIDTH (CW),
    .FLUSH_CYCLES  (2),
    .CNT_WIDTH     (4)
  ) dut (
    .CLK                          (CLK),
    .RST_N                        (RST_N),
    .PC_MISPREDICT_SELECT         (mis),
    .LOAD_USE_HAZARD              (lu),
    .ICACHE_HIT                   (hit),
    .MEM_LOAD_STORE               (mls),
    .DCACHE_READY                 (drdy),
    .STALL_PROGRAME_COUNTER_STAGE (s_pc),
    .STALL_IF_ID                  (s_ifid),
    .STALL_ID_EX                  (s_idex),
    .FLUSH_IF_ID                  (f_ifid),
    .FLUSH_ID_EX                  (f_idex),
    .STATE                        (state),
    .MISPREDICT_COUNT             (mcount),
    .STALL_CYCLE_COUNT            (scount)
  );

  always #5 CLK = ~CLK;

  // Monitor: compare the DUT against the oldest expectation on each falling edge.
  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      exp_t  g;
      string n;
      e = sb_q.pop_front();
      n = name_q.pop_front();
      g = '{ctl: {s_pc, s_ifid, s_idex, f_ifid, f_idex}, st: state, mc: mcount, sc: scount};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got ctl=%b st=%0d mc=%0d sc=%0d, expected ctl=%b st=%0d mc=%0d sc=%0d",
                 n, g.ctl, g.st, g.mc, g.sc, e.ctl, e.st, e.mc, e.sc);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue its expectation.
  task automatic step(input logic r, input logic m, input logic l, input logic h,
                      input logic ls, input logic dr, input logic [4:0] ctl,
                      input logic [1:0] st, input int mc, input int sc, input string n);
    @(posedge CLK);
    #1;
    RST_N = r; mis = m; lu = l; hit = h; mls = ls; drdy = dr;
    sb_q.push_back('{ctl: ctl, st: st, mc: CW'(mc), sc: CW'(sc)});
    name_q.push_back(n);
  endtask

  task automatic do_reset(input string n);
    step(0, 0, 0, 1, 0, 0, 5'b11111, 2'd0, 0, 0, n);
  endtask

  initial begin
    // 1: reset held, then released
    for (int i = 0; i < 3; i++) do_reset("reset_hold");
    step(1, 0, 0, 1, 0, 0, 5'b00000, 2'd0, 0, 0, "reset_release");

    // 2: single mispredict, two flush cycles
    do_reset("t2_reset");
    step(1, 1, 0, 1, 0, 0, 5'b00011, 2'd0, 0, 0, "mispredict_c0");
    step(1, 0, 0, 1, 0, 0, 5'b00010, 2'd3, 1, 0, "mispredict_c1");
    step(1, 0, 0, 1, 0, 0, 5'b00000, 2'd0, 1, 0, "mispredict_c2");

    // 2b: mispredict during REDIRECT restarts; load-use/I-miss masked in REDIRECT
    do_reset("t2b_reset");
    step(1, 1, 0, 1, 0, 0, 5'b00011, 2'd0, 0, 0, "remis_c0");
    step(1, 1, 0, 1, 0, 0, 5'b00011, 2'd3, 1, 0, "remis_c1");
    step(1, 0, 1, 0, 0, 0, 5'b00010, 2'd3, 2, 0, "remis_masked");
    step(1, 0, 0, 1, 0, 0, 5'b00000, 2'd0, 2, 0, "remis_done");

    // 3: load-use for two cycles
    do_reset("t3_reset");
    step(1, 0, 1, 1, 0, 0, 5'b11001, 2'd0, 0, 0, "loaduse_c0");
    step(1, 0, 1, 1, 0, 0, 5'b11001, 2'd0, 0, 1, "loaduse_c1");
    step(1, 0, 0, 1, 0, 0, 5'b00000, 2'd0, 0, 2, "loaduse_end");

    // 4: I-miss for four cycles, then hit
    do_reset("t4_reset");
    step(1, 0, 0, 0, 0, 0, 5'b10010, 2'd0, 0, 0, "imiss_c0");
    step(1, 0, 0, 0, 0, 0, 5'b10010, 2'd1, 0, 1, "imiss_c1");
    step(1, 0, 0, 0, 0, 0, 5'b10010, 2'd1, 0, 2, "imiss_c2");
    step(1, 0, 0, 0, 0, 0, 5'b10010, 2'd1, 0, 3, "imiss_c3");
    step(1, 0, 0, 1, 0, 0, 5'b00000, 2'd1, 0, 4, "imiss_hit");
    step(1, 0, 0, 1, 0, 0, 5'b00000, 2'd0, 0, 4, "imiss_run");

    // 5: D-cache block overrides a held mispredict
    do_reset("t5_reset");
    step(1, 1, 0, 1, 1, 0, 5'b11100, 2'd0, 0, 0, "dmiss_c0");
    step(1, 1, 0, 1, 1, 0, 5'b11100, 2'd2, 0, 1, "dmiss_c1");
    step(1, 1, 0, 1, 1, 0, 5'b11100, 2'd2, 0, 2, "dmiss_c2");
    step(1, 1, 0, 1, 1, 1, 5'b00011, 2'd2, 0, 3, "dmiss_release");
    step(1, 0, 0, 1, 0, 0, 5'b00010, 2'd3, 1, 3, "dmiss_redirect");
    step(1, 0, 0, 1, 0, 0, 5'b00000, 2'd0, 1, 3, "dmiss_run");

    // 6: stall counter saturation, then asynchronous reset mid-miss
    do_reset("t6_reset");
    for (int i = 0; i < 19; i++)
      step(1, 0, 0, 0, 0, 0, 5'b10010, (i == 0) ? 2'd0 : 2'd1, 0, (i > 15) ? 15 : i, "sat_imiss");
    step(0, 0, 0, 0, 0, 0, 5'b11111, 2'd0, 0, 0, "async_reset_mid_imiss");
    step(1, 0, 0, 1, 0, 0, 5'b00000, 2'd0, 0, 0, "post_reset_run");

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
